ipg_msg_sched: RTL and testbench
================================

# ipg_msg_sched

Message-atomic egress scheduler for one output virtual port of the IPG switch fabric. Each ingress virtual port keeps three message queues: rreq, rresp and wreq. The block picks one (port, type) pair and drains that queue's head message beat by beat until the delimiter beat has gone out. Only then does it re-arbitrate: strict type priority rreq > rresp > wreq, and round-robin across ports within each type. It sits between the ivport queue array and the TX IPG insertion slot, and drives the queue pop strobes and the egress IPG data.

## Interface
- PORT_NUM, 4, number of ivports; must be ≥2.
- DATA_WIDTH, 64, IPG message beat width.
- STARVE_LIMIT, 8, message grants lost before a lower type is promoted; aging build only.
- MAX_MSG_BEATS, 16, beat cap per message before forced abort.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rreq_empty  in  PORT_NUM  per-port rreq queue empty.
- rresp_empty  in  PORT_NUM  per-port rresp queue empty.
- wreq_empty  in  PORT_NUM  per-port wreq queue empty.
- fire_ipg_data_flat  in  DATA_WIDTH*PORT_NUM  head beat of each port's selected-type queue; port k at [k*DATA_WIDTH +: DATA_WIDTH].
- tx_slot  in  1  downstream IPG slot available this cycle.
- fire_en  out  PORT_NUM  one-hot pop strobe to the locked port.
- fire_type_sel  out  2  locked type: 0 rreq, 1 rresp, 2 wreq, 3 none.
- tx_ipg_en  out  1  tx_ipg_data valid.
- tx_ipg_data  out  DATA_WIDTH  egress beat.
- busy  out  1  a message is locked.
- abort  out  1  one-cycle pulse on beat-cap abort.

## Operation
- FSM has two states: IDLE and BURST.
- **IDLE**
  - A type is a candidate if any of its ports is non-empty.
  - The highest-priority candidate type wins.
  - Port choice: first non-empty port at or after rr_ptr[type], searching modulo PORT_NUM.
  - On a winner, register lock_type and lock_port, clear beat_cnt, go to BURST.
  - With no candidate, stay in IDLE with fire_type_sel=3.
- **BURST**
  - fire_type_sel = lock_type.
  - Fire condition: tx_slot & !empty[lock_type][lock_port]. When it holds, fire_en[lock_port]=1 and tx_ipg_en=1, and tx_ipg_data is the head beat of lock_port.
  - A fired beat with tx_ipg_data[7:4]==0 is the delimiter. On it: rr_ptr[lock_type] ← (lock_port+1) mod PORT_NUM, then go to IDLE.
  - Each fired non-delimiter beat increments beat_cnt.
  - If beat_cnt reaches MAX_MSG_BEATS without a delimiter: pulse abort the next cycle, go to IDLE, and advance rr_ptr as for a delimiter.
- Queue empty mid-message: stall in BURST with no fire. Other types and ports are never interleaved into a locked message.
- tx_slot low: no fire, lock held.
- fire_en, tx_ipg_en and tx_ipg_data are combinational from the registered state. tx_ipg_data = 0 when tx_ipg_en=0.
- busy = (state==BURST).

## Timing
- Reset values: state IDLE, rr_ptr all 0, beat_cnt 0, starve counters 0. Outputs: fire_en 0, fire_type_sel 3, tx_ipg_en 0, tx_ipg_data 0, busy 0, abort 0.
- Latency:
  - A non-empty queue seen in IDLE at edge N gives its first beat in cycle N+1, given tx_slot.
  - A one-beat message therefore costs 2 cycles.
  - Back-to-back messages have exactly one IDLE cycle between them.
- Empty flags are sampled in the same cycle as the fire. A pop takes effect at the next edge.
- Reset mid-message drops the lock with no pop in the reset cycle. The queue remainder is upstream's responsibility.
- Width rules:
  - rr_ptr and lock_port are $clog2(PORT_NUM) bits, wrapping modulo PORT_NUM even for non-power-of-2 values.
  - beat_cnt is $clog2(MAX_MSG_BEATS+1) bits and saturates.

## Configuration
- Macro: IPG_SCHED_AGING_EN.
- **Defined:** rresp and wreq each get a starve counter ($clog2(STARVE_LIMIT+1) bits, saturating).
  - The counter increments when a lock is granted to a higher-priority type while this type is a candidate.
  - At STARVE_LIMIT the type outranks every non-promoted type at the next IDLE selection.
  - If both are promoted, rresp wins.
  - The counter clears when its type is granted.
- **Undefined:** strict priority, no counters. Lower types may starve indefinitely.

## Structure
- Package ipg_sched_pkg holds:
  - type codes TYPE_RREQ=0, TYPE_RRESP=1, TYPE_WREQ=2, TYPE_NONE=3;
  - state encoding;
  - delimiter field position [7:4] and value 0.
- Sub-module rr_pick: round-robin first-set-at-or-after-pointer over PORT_NUM bits. Outputs are index and found. It is instantiated once per type.

## Test plan
- Reset with all queues empty, tx_slot=1 → fire_en=0, fire_type_sel=3, tx_ipg_en=0, busy=0 for 10 cycles.
- rreq@p2 message of 3 beats (last beat [7:4]=0) and wreq@p0 message of 1 beat present together → fire_en=4'b0100 on cycles 1–3, one IDLE cycle, then fire_en=4'b0001 with fire_type_sel=2.
- rreq 1-beat messages queued on p0, p1, p3 → grant order p0, p1, p3, p0; rr_ptr=1 after the first grant.
- Mid-message, tx_slot low for 3 cycles, then the queue empty for 2 cycles while rresp@p1 is non-empty → no fire, lock stays on rreq, no rresp beat until the delimiter.
- MAX_MSG_BEATS=4, message of 6 beats with no delimiter → 4 beats fired, abort=1 for one cycle, then IDLE; the next grant starts at lock_port+1.
- STARVE_LIMIT=2, rreq@p0 continuously non-empty with 1-beat messages, wreq@p1 non-empty:
  - with IPG_SCHED_AGING_EN: third grant is wreq@p1;
  - without it: wreq is never granted in 50 cycles.

Source files
------------

// File: rtl/ipg_sched_pkg.sv
// rtl/ipg_sched_pkg.sv - type codes, FSM encoding and delimiter field for ipg_msg_sched
package ipg_sched_pkg;

    localparam logic [1:0] TYPE_RREQ  = 2'd0;
    localparam logic [1:0] TYPE_RRESP = 2'd1;
    localparam logic [1:0] TYPE_WREQ  = 2'd2;
    localparam logic [1:0] TYPE_NONE  = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam int         DELIM_LSB = 4;
    localparam int         DELIM_MSB = 7;
    localparam logic [3:0] DELIM_VAL = 4'd0;

    function automatic logic is_delim(input logic [7:0] low_byte);
        return low_byte[DELIM_MSB:DELIM_LSB] == DELIM_VAL;
    endfunction

endpackage

// File: rtl/ipg_msg_sched_rr_pick.sv
// rtl/ipg_msg_sched_rr_pick.sv - first set bit at or after ptr, searching modulo N
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int pos;
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = pos[$clog2(N)-1:0];
            end
        end
    end

endmodule

// File: rtl/ipg_msg_sched.sv
// rtl/ipg_msg_sched.sv - message-atomic egress scheduler, rreq > rresp > wreq, RR across ports
// Optional starvation aging of rresp/wreq: define IPG_SCHED_AGING_EN.
module ipg_msg_sched
    import ipg_sched_pkg::*;
#(
    parameter int PORT_NUM      = 4,
    parameter int DATA_WIDTH    = 64,
    parameter int STARVE_LIMIT  = 8,
    parameter int MAX_MSG_BEATS = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PORT_NUM-1:0]            rreq_empty,
    input  logic [PORT_NUM-1:0]            rresp_empty,
    input  logic [PORT_NUM-1:0]            wreq_empty,
    input  logic [DATA_WIDTH*PORT_NUM-1:0] fire_ipg_data_flat,
    input  logic                           tx_slot,
    output logic [PORT_NUM-1:0]            fire_en,
    output logic [1:0]                     fire_type_sel,
    output logic                           tx_ipg_en,
    output logic [DATA_WIDTH-1:0]          tx_ipg_data,
    output logic                           busy,
    output logic                           abort
);

    localparam int PW = $clog2(PORT_NUM);
    localparam int BW = $clog2(MAX_MSG_BEATS + 1);

    if (PORT_NUM < 2 || DATA_WIDTH < 8 || MAX_MSG_BEATS < 1 || STARVE_LIMIT < 1) begin : g_param_check
        $error("ipg_msg_sched: illegal parameter set");
    end

    state_t                state;
    logic [1:0]            lock_type;
    logic [PW-1:0]         lock_port;
    logic [BW-1:0]         beat_cnt;
    logic [PW-1:0]         rr_ptr     [3];
    logic [PORT_NUM-1:0]   type_req   [3];
    logic [PW-1:0]         pick_idx   [3];
    logic [2:0]            pick_found;
    logic [1:0]            win_type;
    logic [PW-1:0]         win_port;
    logic [PW-1:0]         nxt_port;
    logic                  lock_empty;
    logic                  fire;
    logic                  delim;
    logic                  msg_done;
    logic [DATA_WIDTH-1:0] head_beat;

`ifdef IPG_SCHED_AGING_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_rresp;
    logic [SW-1:0] starve_wreq;
`endif

    assign type_req[0] = ~rreq_empty;
    assign type_req[1] = ~rresp_empty;
    assign type_req[2] = ~wreq_empty;

    for (genvar t = 0; t < 3; t++) begin : g_pick
        rr_pick #(.N(PORT_NUM)) u_pick (
            .req   (type_req[t]),
            .ptr   (rr_ptr[t]),
            .idx   (pick_idx[t]),
            .found (pick_found[t])
        );
    end

    // Later assignments override earlier ones, so promotion beats base priority.
    always_comb begin
        win_type = TYPE_NONE;
        if (pick_found[2]) win_type = TYPE_WREQ;
        if (pick_found[1]) win_type = TYPE_RRESP;
        if (pick_found[0]) win_type = TYPE_RREQ;
`ifdef IPG_SCHED_AGING_EN
        if (pick_found[2] && starve_wreq >= SW'(STARVE_LIMIT))  win_type = TYPE_WREQ;
        if (pick_found[1] && starve_rresp >= SW'(STARVE_LIMIT)) win_type = TYPE_RRESP;
`endif
        case (win_type)
            TYPE_RREQ:  win_port = pick_idx[0];
            TYPE_RRESP: win_port = pick_idx[1];
            TYPE_WREQ:  win_port = pick_idx[2];
            default:    win_port = '0;
        endcase
    end

    always_comb begin
        case (lock_type)
            TYPE_RREQ:  lock_empty = rreq_empty[lock_port];
            TYPE_RRESP: lock_empty = rresp_empty[lock_port];
            TYPE_WREQ:  lock_empty = wreq_empty[lock_port];
            default:    lock_empty = 1'b1;
        endcase
    end

    assign head_beat = fire_ipg_data_flat[int'(lock_port)*DATA_WIDTH +: DATA_WIDTH];
    // Gated by rst so a lock dropped by reset never pops in the reset cycle.
    assign fire      = (state == ST_BURST) && tx_slot && !lock_empty && !rst;
    assign delim     = is_delim(head_beat[7:0]);
    assign msg_done  = fire && (delim || beat_cnt >= BW'(MAX_MSG_BEATS - 1));
    assign nxt_port  = (lock_port == PW'(PORT_NUM - 1)) ? '0 : lock_port + 1'b1;

    assign fire_en       = fire ? (PORT_NUM'(1) << lock_port) : '0;
    assign tx_ipg_en     = fire;
    assign tx_ipg_data   = fire ? head_beat : '0;
    assign fire_type_sel = (state == ST_BURST) ? lock_type : TYPE_NONE;
    assign busy          = (state == ST_BURST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            lock_type <= TYPE_NONE;
            lock_port <= '0;
            beat_cnt  <= '0;
            abort     <= 1'b0;
            for (int t = 0; t < 3; t++) rr_ptr[t] <= '0;
`ifdef IPG_SCHED_AGING_EN
            starve_rresp <= '0;
            starve_wreq  <= '0;
`endif
        end else begin
            abort <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_type != TYPE_NONE) begin
                        lock_type <= win_type;
                        lock_port <= win_port;
                        beat_cnt  <= '0;
                        state     <= ST_BURST;
`ifdef IPG_SCHED_AGING_EN
                        if (win_type == TYPE_RRESP)
                            starve_rresp <= '0;
                        else if (win_type == TYPE_RREQ && pick_found[1] && starve_rresp < SW'(STARVE_LIMIT))
                            starve_rresp <= starve_rresp + 1'b1;
                        if (win_type == TYPE_WREQ)
                            starve_wreq <= '0;
                        else if (pick_found[2] && starve_wreq < SW'(STARVE_LIMIT))
                            starve_wreq <= starve_wreq + 1'b1;
`endif
                    end
                end
                ST_BURST: begin
                    if (fire && !delim && beat_cnt < BW'(MAX_MSG_BEATS))
                        beat_cnt <= beat_cnt + 1'b1;
                    if (msg_done) begin
                        abort <= !delim;
                        state <= ST_IDLE;
                        for (int t = 0; t < 3; t++)
                            if (lock_type == 2'(t)) rr_ptr[t] <= nxt_port;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ipg_msg_sched.sv
// tb/tb_ipg_msg_sched.sv - self-checking bench for ipg_msg_sched with queue-level reference model
module tb_ipg_msg_sched;

    localparam int NP    = 4;
    localparam int DW    = 64;
    localparam int LIM   = 2;
    localparam int MAXB  = 4;
    localparam int DEPTH = 256;
    localparam int LOGSZ = 4096;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clr = 1'b1;
    logic [NP-1:0]      rreq_empty, rresp_empty, wreq_empty;
    logic [DW*NP-1:0]   fire_ipg_data_flat;
    logic               tx_slot = 1'b1;
    logic [NP-1:0]      fire_en;
    logic [1:0]         fire_type_sel;
    logic               tx_ipg_en;
    logic [DW-1:0]      tx_ipg_data;
    logic               busy;
    logic               abort;

    logic [63:0] mem  [3][NP][DEPTH];
    int          head [3][NP];
    int          tail [3][NP];

    int          cyc, log_n, abort_n, bad_pop;
    logic [1:0]  log_type [LOGSZ];
    logic [3:0]  log_en   [LOGSZ];
    logic [63:0] log_data [LOGSZ];
    int          log_cyc  [LOGSZ];

    int n_checks = 0;
    int n_fail   = 0;

    ipg_msg_sched #(
        .PORT_NUM(NP), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM), .MAX_MSG_BEATS(MAXB)
    ) dut (
        .clk(clk), .rst(rst),
        .rreq_empty(rreq_empty), .rresp_empty(rresp_empty), .wreq_empty(wreq_empty),
        .fire_ipg_data_flat(fire_ipg_data_flat), .tx_slot(tx_slot),
        .fire_en(fire_en), .fire_type_sel(fire_type_sel), .tx_ipg_en(tx_ipg_en),
        .tx_ipg_data(tx_ipg_data), .busy(busy), .abort(abort)
    );

    always #5 clk = ~clk;

    // Upstream queue array: empties per type, head beat of the selected type per port.
    always_comb begin
        int s;
        s = int'(fire_type_sel);
        fire_ipg_data_flat = '0;
        for (int p = 0; p < NP; p++) begin
            rreq_empty[p]  = (head[0][p] == tail[0][p]);
            rresp_empty[p] = (head[1][p] == tail[1][p]);
            wreq_empty[p]  = (head[2][p] == tail[2][p]);
            if (s < 3 && head[s][p] != tail[s][p])
                fire_ipg_data_flat[p*DW +: DW] = mem[s][p][head[s][p] % DEPTH];
        end
    end

    always @(posedge clk) begin
        int s;
        s = int'(fire_type_sel);
        cyc <= cyc + 1;
        if (clr) begin
            for (int t = 0; t < 3; t++)
                for (int p = 0; p < NP; p++) head[t][p] <= tail[t][p];
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (fire_en[p]) begin
                    if (s == 3) bad_pop <= bad_pop + 1;
                    else if (head[s][p] == tail[s][p]) bad_pop <= bad_pop + 1;
                    else head[s][p] <= head[s][p] + 1;
                end
            end
        end
        if (tx_ipg_en && log_n < LOGSZ) begin
            log_type[log_n] <= fire_type_sel;
            log_en[log_n]   <= fire_en;
            log_data[log_n] <= tx_ipg_data;
            log_cyc[log_n]  <= cyc;
            log_n           <= log_n + 1;
        end
        if (abort) abort_n <= abort_n + 1;
    end

    function automatic logic [63:0] mk_beat(input bit last);
        logic [63:0] d;
        d = {$urandom, $urandom};
        if (last) d[7:4] = 4'h0;
        else if (d[7:4] == 4'h0) d[7:4] = 4'h9;
        return d;
    endfunction

    task automatic push(input int t, input int p, input logic [63:0] d);
        mem[t][p][tail[t][p] % DEPTH] = d;
        tail[t][p] = tail[t][p] + 1;
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; clr = 1'b1; tx_slot = 1'b1;
        to_pos();
        to_pos();
        rst = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b1; tx_slot = 1'b1;
        to_pos();
        @(negedge clk);
        n_checks++;
        if ({fire_en, fire_type_sel, tx_ipg_en, busy, abort} !== 9'b0000_11_000 || tx_ipg_data !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: en=%b sel=%0d txen=%b busy=%b abort=%b data=%h", fire_en, fire_type_sel, tx_ipg_en, busy, abort, tx_ipg_data);
        end
        to_pos();
        rst = 1'b0; clr = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if ({fire_en, fire_type_sel, tx_ipg_en, busy, abort} !== 9'b0000_11_000 || tx_ipg_data !== '0) begin
                n_fail++;
                $display("FAIL reset_idle c%0d: en=%b sel=%0d txen=%b busy=%b abort=%b, want 0/3/0/0/0", c, fire_en, fire_type_sel, tx_ipg_en, busy, abort);
            end
            to_pos();
        end
    endtask

    task automatic test_type_priority();
        logic [63:0] d [4];
        logic [3:0]  een  [6] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001};
        logic [1:0]  esel [6] = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2};
        logic [63:0] edat [6];
        reset_dut();
        d[0] = mk_beat(0); d[1] = mk_beat(0); d[2] = mk_beat(1); d[3] = mk_beat(1);
        edat = '{64'd0, d[0], d[1], d[2], 64'd0, d[3]};
        push(0, 2, d[0]); push(0, 2, d[1]); push(0, 2, d[2]);
        push(2, 0, d[3]);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if ({fire_en, fire_type_sel, busy} !== {een[c], esel[c], esel[c] != 2'd3}) begin
                n_fail++;
                $display("FAIL prio_ctl c%0d: en=%b sel=%0d busy=%b, want en=%b sel=%0d", c, fire_en, fire_type_sel, busy, een[c], esel[c]);
            end
            n_checks++;
            if (tx_ipg_data !== edat[c] || tx_ipg_en !== (een[c] != 4'b0)) begin
                n_fail++;
                $display("FAIL prio_data c%0d: data=%h en=%b, want %h", c, tx_ipg_data, tx_ipg_en, edat[c]);
            end
            to_pos();
        end
    endtask

    task automatic test_round_robin();
        int base, c0;
        logic [3:0] eport [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        reset_dut();
        push(0, 0, mk_beat(1)); push(0, 1, mk_beat(1)); push(0, 3, mk_beat(1)); push(0, 0, mk_beat(1));
        base = log_n;
        c0 = cyc;
        for (int c = 0; c < 10; c++) to_pos();
        n_checks++;
        if (log_n - base != 4) begin
            n_fail++;
            $display("FAIL rr_count: got %0d grants, want 4", log_n - base);
        end
        n_checks++;
        if (log_cyc[base] !== c0 + 1) begin
            n_fail++;
            $display("FAIL rr_latency: first beat in cycle %0d, want %0d", log_cyc[base] - c0, 1);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (log_en[base+i] !== eport[i] || log_type[base+i] !== 2'd0) begin
                n_fail++;
                $display("FAIL rr_order #%0d: en=%b type=%0d, want en=%b type=0", i, log_en[base+i], log_type[base+i], eport[i]);
            end
            if (i > 0) begin
                n_checks++;
                if (log_cyc[base+i] - log_cyc[base+i-1] != 2) begin
                    n_fail++;
                    $display("FAIL rr_spacing #%0d: gap %0d cycles, want 2", i, log_cyc[base+i] - log_cyc[base+i-1]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [63:0] b0, b1, b2, r1;
        bit          tx   [11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        logic [3:0]  een  [11] = '{0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 2};
        logic [1:0]  esel [11] = '{3, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1};
        logic [63:0] edat [11];
        reset_dut();
        b0 = mk_beat(0); b1 = mk_beat(0); b2 = mk_beat(1); r1 = mk_beat(1);
        edat = '{0, b0, 0, 0, 0, b1, 0, 0, b2, 0, r1};
        push(0, 0, b0); push(0, 0, b1);
        push(1, 1, r1);
        for (int c = 0; c < 11; c++) begin
            tx_slot = tx[c];
            if (c == 8) push(0, 0, b2);
            @(negedge clk);
            n_checks++;
            if ({fire_en, fire_type_sel} !== {een[c], esel[c]} || tx_ipg_data !== edat[c]) begin
                n_fail++;
                $display("FAIL stall c%0d: en=%b sel=%0d data=%h, want en=%b sel=%0d data=%h", c, fire_en, fire_type_sel, tx_ipg_data, een[c], esel[c], edat[c]);
            end
            to_pos();
        end
        tx_slot = 1'b1;
    endtask

    task automatic test_abort();
        logic [63:0] a [6];
        logic [63:0] q3;
        logic [3:0]  een  [8] = '{0, 4, 4, 4, 4, 0, 8, 0};
        logic [1:0]  esel [8] = '{3, 2, 2, 2, 2, 3, 2, 3};
        bit          eab  [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
        logic [63:0] edat [8];
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            a[i] = mk_beat(0);
            push(2, 2, a[i]);
        end
        q3 = mk_beat(1);
        push(2, 3, q3);
        edat = '{0, a[0], a[1], a[2], a[3], 0, q3, 0};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_checks++;
            if ({fire_en, fire_type_sel, abort} !== {een[c], esel[c], eab[c]} || tx_ipg_data !== edat[c]) begin
                n_fail++;
                $display("FAIL abort c%0d: en=%b sel=%0d abort=%b data=%h, want en=%b sel=%0d abort=%b data=%h", c, fire_en, fire_type_sel, abort, tx_ipg_data, een[c], esel[c], eab[c], edat[c]);
            end
            to_pos();
        end
        // Remainder of p2 is now locked; reset must drop it without a pop.
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (fire_en !== 4'b0 || tx_ipg_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midmsg: en=%b txen=%b, want 0/0", fire_en, tx_ipg_en);
        end
        to_pos();
        n_checks++;
        if (tail[2][2] - head[2][2] != 2) begin
            n_fail++;
            $display("FAIL reset_nopop: %0d beats left on wreq p2, want 2", tail[2][2] - head[2][2]);
        end
        rst = 1'b0;
    endtask

    task automatic test_starve();
        int base, nw;
        reset_dut();
        for (int i = 0; i < 30; i++) push(0, 0, mk_beat(1));
        push(2, 1, mk_beat(1));
        base = log_n;
        for (int c = 0; c < 50; c++) to_pos();
        nw = 0;
        for (int i = base; i < log_n; i++) if (log_type[i] == 2'd2) nw++;
        n_checks++;
        if (log_n - base != 25) begin
            n_fail++;
            $display("FAIL starve_count: %0d grants in 50 cycles, want 25", log_n - base);
        end
`ifdef IPG_SCHED_AGING_EN
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({log_type[base+i], log_en[base+i]} !== ((i == 2) ? {2'd2, 4'b0010} : {2'd0, 4'b0001})) begin
                n_fail++;
                $display("FAIL starve_aging #%0d: type=%0d en=%b", i, log_type[base+i], log_en[base+i]);
            end
        end
`else
        n_checks++;
        if (nw != 0) begin
            n_fail++;
            $display("FAIL starve_strict: wreq granted %0d times, want 0", nw);
        end
`endif
    endtask

    task automatic test_random();
        int          mh [3][NP];
        int          ptr [3];
        int          s1, s2, g, p, n, exp_n, exp_ab, base, abase, t, pp;
        bit          cand [3];
        logic [1:0]  et [512];
        logic [3:0]  ee [512];
        logic [63:0] ed [512];
        logic [63:0] d;
        reset_dut();
        for (int m = 0; m < 40; m++) begin
            int len;
            t   = $urandom_range(0, 2);
            pp  = $urandom_range(0, NP - 1);
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) push(t, pp, mk_beat(b == len - 1));
        end
        for (int i = 0; i < 3; i++) begin
            ptr[i] = 0;
            for (int j = 0; j < NP; j++) mh[i][j] = head[i][j];
        end
        s1 = 0; s2 = 0; exp_n = 0; exp_ab = 0;
        while (1) begin
            for (int i = 0; i < 3; i++) begin
                cand[i] = 0;
                for (int j = 0; j < NP; j++) if (mh[i][j] != tail[i][j]) cand[i] = 1;
            end
            if (!cand[0] && !cand[1] && !cand[2]) break;
            g = cand[0] ? 0 : (cand[1] ? 1 : 2);
`ifdef IPG_SCHED_AGING_EN
            if (cand[2] && s2 >= LIM) g = 2;
            if (cand[1] && s1 >= LIM) g = 1;
            if (g == 1) s1 = 0; else if (g == 0 && cand[1] && s1 < LIM) s1++;
            if (g == 2) s2 = 0; else if (cand[2] && s2 < LIM) s2++;
`endif
            p = -1;
            for (int k = 0; k < NP; k++) begin
                pp = (ptr[g] + k) % NP;
                if (p < 0 && mh[g][pp] != tail[g][pp]) p = pp;
            end
            n = 0;
            while (mh[g][p] != tail[g][p]) begin
                d = mem[g][p][mh[g][p] % DEPTH];
                mh[g][p]++;
                et[exp_n] = 2'(g); ee[exp_n] = 4'(1) << p; ed[exp_n] = d;
                exp_n++; n++;
                if (d[7:4] == 4'h0) break;
                if (n == MAXB) begin
                    exp_ab++;
                    break;
                end
            end
            ptr[g] = (p + 1) % NP;
        end
        base = log_n;
        abase = abort_n;
        for (int c = 0; c < 3000 && (log_n - base) < exp_n; c++) begin
            tx_slot = ($urandom_range(0, 3) != 0);
            to_pos();
        end
        tx_slot = 1'b1;
        to_pos();
        to_pos();
        n_checks++;
        if (log_n - base != exp_n) begin
            n_fail++;
            $display("FAIL rand_count: %0d beats, want %0d", log_n - base, exp_n);
        end
        for (int i = 0; i < exp_n && i < log_n - base; i++) begin
            n_checks++;
            if ({log_type[base+i], log_en[base+i], log_data[base+i]} !== {et[i], ee[i], ed[i]}) begin
                n_fail++;
                $display("FAIL rand_beat #%0d: type=%0d en=%b data=%h, want type=%0d en=%b data=%h", i, log_type[base+i], log_en[base+i], log_data[base+i], et[i], ee[i], ed[i]);
            end
        end
        n_checks++;
        if (abort_n - abase != exp_ab) begin
            n_fail++;
            $display("FAIL rand_aborts: %0d, want %0d", abort_n - abase, exp_ab);
        end
    endtask

    initial begin
        test_reset();
        test_type_priority();
        test_round_robin();
        test_stall();
        test_abort();
        test_starve();
        test_random();
        n_checks++;
        if (bad_pop != 0) begin
            n_fail++;
            $display("FAIL pop_underflow: %0d pops from empty/none, want 0", bad_pop);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
